multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the MIPS-subset datapath. It replaces per-instruction single-cycle decode with a Moore FSM that steps a shared ALU, a unified instruction/data memory and the register file through fetch, decode, execute, memory and write-back cycles. It supports R-type, lw, sw, beq, j, jal, addi and subi, and stalls on a memory-ready handshake. It sits between the instruction register and the datapath muxes/enables.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; sampled in DECODE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero (beq).
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite, IRWrite, RegWrite  out  1 each  enables.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- ALUOp  out  3  0 add, 1 sub, 2 addi, 3 subi, 4 use funct.
- RegDst  out  2  0 = rt, 1 = rd, 2 = $31.
- MemToReg  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
- PCSource  out  2  0 = ALU result, 1 = ALUOut (branch target), 2 = jump target.
- state  out  4  current state, for debug.
- instr_done  out  1  final cycle of an instruction.
- halted  out  1  sticky; illegal opcode seen.

## Operation
- Outputs are a function of state only, except where marked "gated". Every output not listed for a state is 0.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. IRWrite and PCWrite are gated (= mem_ready). Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE (1): ALUSrcA=0, ALUSrcB=3, ALUOp=0 (precompute branch target). Latches opcode into op_q.
  - 0x00 -> EXEC
  - 0x23, 0x2B -> MEMADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - 0x08, 0x09 -> IEXEC
  - other -> HALT
- MEMADDR (2): ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to MEMRD if op_q=0x23, else MEMWR.
- MEMRD (3): MemRead=1, IorD=1. Waits for mem_ready, then MEMWB.
- MEMWB (4): RegWrite=1, RegDst=0, MemToReg=1, instr_done=1 -> FETCH.
- MEMWR (5): MemWrite=1, IorD=1. instr_done is gated (= mem_ready). Goes to FETCH on mem_ready.
- EXEC (6): ALUSrcA=1, ALUSrcB=0, ALUOp=4 -> RWB.
- RWB (7): RegWrite=1, RegDst=1, MemToReg=0, instr_done=1 -> FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, instr_done=1 -> FETCH.
- JUMP (9): PCWrite=1, PCSource=2, instr_done=1 -> FETCH.
- JAL (10): PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemToReg=2, instr_done=1 -> FETCH. The PC written to $31 is the already-incremented PC+4.
- IEXEC (11): ALUSrcA=1, ALUSrcB=2, ALUOp=2 if op_q=0x08, else 3 -> IWB.
- IWB (12): RegWrite=1, RegDst=0, MemToReg=0, instr_done=1 -> FETCH.
- HALT (13): halted=1, all enables 0. Stays in HALT until rst.
- Unused encodings 14–15 go to FETCH on the next edge, with all outputs 0.

## Timing
- Reset: rst=1 at an edge forces state=FETCH and op_q=0. halted is derived from state, so it reads 0.
  - Outputs after reset are the FETCH values: MemRead=1, ALUSrcB=1, IRWrite=PCWrite=mem_ready; everything else 0.
  - rst has priority over every transition, including mid-instruction and HALT.
- Cycle counts with mem_ready held at 1 (including FETCH):
  - lw 5
  - R-type, sw, addi, subi 4
  - beq, j, jal 3
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. No enable fires while stalled.
- mem_ready is ignored in all other states.
- opcode is only sampled in DECODE; changes at any other time have no effect.
- instr_done is high for exactly one cycle per retired instruction. The next cycle is FETCH.

## Test plan
- Reset then an R-type (0x00) with mem_ready=1: states 0,1,6,7,0. IRWrite/PCWrite high only in cycle 0. RegWrite=1 and RegDst=1 in cycle 3. instr_done pulses once.
- lw (0x23) with mem_ready low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 throughout MEMRD. RegWrite and MemToReg=1 only in MEMWB.
- sw (0x2B) then beq (0x04): MemWrite asserted only in state 5. Then states 0,1,8 with PCWriteCond=1, ALUOp=1, PCSource=1. Total 7 cycles.
- jal (0x03): state 10 drives PCWrite=1, PCSource=2, RegDst=2, MemToReg=2, RegWrite=1. addi (0x08) gives ALUOp=2 in IEXEC; subi (0x09) gives ALUOp=3.
- Opcode 0x3F: DECODE -> HALT. halted=1 with all enables 0 for 10 or more cycles. A 1-cycle rst pulse returns to FETCH with halted=0.
- Assert rst in MEMRD while mem_ready=0: next state is FETCH, and no RegWrite pulse occurs.

Source files
------------

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode/handshake inputs and datapath control outputs of the multicycle sequencer
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] pcsource;
    logic [3:0] state;
    logic       instr_done;
    logic       halted;

    modport slave (
        input  opcode, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite,
               alusrca, alusrcb, aluop, regdst, memtoreg, pcsource, state, instr_done, halted
    );

    modport master (
        output opcode, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite,
               alusrca, alusrcb, aluop, regdst, memtoreg, pcsource, state, instr_done, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing fetch/decode/execute/memory/write-back for the MIPS-subset datapath
module multicycle_control (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC, RWB,
        BRANCH, JUMP, JAL, IEXEC, IWB, HALT, UNUSED14, UNUSED15
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] pcsource;
        logic       done;
        logic       halted;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t     st;
    state_t     nxt;
    logic [5:0] op_q;
    logic [5:0] nop;
    ctl_t       ctl;

    function automatic state_t next_of(state_t s, logic [5:0] op, logic [5:0] opc, logic rdy);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:   n = rdy ? DECODE : FETCH;
            DECODE: begin
                case (opc)
                    OP_RTYPE:        n = EXEC;
                    OP_LW, OP_SW:    n = MEMADDR;
                    OP_BEQ:          n = BRANCH;
                    OP_J:            n = JUMP;
                    OP_JAL:          n = JAL;
                    OP_ADDI, OP_SUBI: n = IEXEC;
                    default:         n = HALT;
                endcase
            end
            MEMADDR: n = op == OP_LW ? MEMRD : MEMWR;
            MEMRD:   n = rdy ? MEMWB : MEMRD;
            MEMWR:   n = rdy ? FETCH : MEMWR;
            EXEC:    n = RWB;
            IEXEC:   n = IWB;
            HALT:    n = HALT;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    // Control word for a state; handshake-gated enables are added on top at the outputs.
    function automatic ctl_t ctl_of(state_t s, logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'd1;
            end
            DECODE:  c.alusrcb = 2'd3;
            MEMADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'd2;
            end
            MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 2'd1;
                c.done     = 1'b1;
            end
            MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 3'd4;
            end
            RWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 2'd1;
                c.done     = 1'b1;
            end
            BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = 3'd1;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'd1;
                c.done        = 1'b1;
            end
            JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'd2;
                c.done     = 1'b1;
            end
            JAL: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'd2;
                c.regwrite = 1'b1;
                c.regdst   = 2'd2;
                c.memtoreg = 2'd2;
                c.done     = 1'b1;
            end
            IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'd2;
                c.aluop   = op == OP_ADDI ? 3'd2 : 3'd3;
            end
            IWB: begin
                c.regwrite = 1'b1;
                c.done     = 1'b1;
            end
            HALT:    c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nop = st == DECODE ? bus.opcode : op_q;
        nxt = next_of(st, op_q, bus.opcode, bus.mem_ready);
    end

    // Control word is registered from the next state so outputs leave flops aligned with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= FETCH;
            op_q <= '0;
            ctl  <= ctl_of(FETCH, 6'h00);
        end else begin
            st   <= nxt;
            op_q <= nop;
            ctl  <= ctl_of(nxt, nop);
        end
    end

    assign bus.pcwrite     = ctl.pcwrite | (st == FETCH && bus.mem_ready);
    assign bus.irwrite     = st == FETCH && bus.mem_ready;
    assign bus.instr_done  = ctl.done | (st == MEMWR && bus.mem_ready);
    assign bus.pcwritecond = ctl.pcwritecond;
    assign bus.iord        = ctl.iord;
    assign bus.memread     = ctl.memread;
    assign bus.memwrite    = ctl.memwrite;
    assign bus.regwrite    = ctl.regwrite;
    assign bus.alusrca     = ctl.alusrca;
    assign bus.alusrcb     = ctl.alusrcb;
    assign bus.aluop       = ctl.aluop;
    assign bus.regdst      = ctl.regdst;
    assign bus.memtoreg    = ctl.memtoreg;
    assign bus.pcsource    = ctl.pcsource;
    assign bus.state       = st;
    assign bus.halted      = ctl.halted;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-step bench with immediate assertions for the multicycle sequencer
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] exp_state);
        @(posedge clk);
        #2;
        check("state", {28'd0, bus.state}, {28'd0, exp_state});
    endtask

    function automatic logic [4:0] enables();
        return {bus.regwrite, bus.memwrite, bus.memread, bus.pcwrite, bus.irwrite};
    endfunction

    initial begin
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_state", {28'd0, bus.state}, 32'd0);
        check("rst_memread", {31'd0, bus.memread}, 32'd1);
        check("rst_alusrcb", {30'd0, bus.alusrcb}, 32'd1);
        check("rst_irwrite", {31'd0, bus.irwrite}, 32'd1);
        check("rst_pcwrite", {31'd0, bus.pcwrite}, 32'd1);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_regwrite", {31'd0, bus.regwrite}, 32'd0);
        bus.mem_ready = 1'b0;
        #1;
        check("fetch_stall_irwrite", {31'd0, bus.irwrite}, 32'd0);
        check("fetch_stall_pcwrite", {31'd0, bus.pcwrite}, 32'd0);
        step(4'd0);
        bus.mem_ready = 1'b1;
        // R-type
        step(4'd1);
        check("dec_irwrite", {31'd0, bus.irwrite}, 32'd0);
        check("dec_alusrcb", {30'd0, bus.alusrcb}, 32'd3);
        step(4'd6);
        check("exec_aluop", {29'd0, bus.aluop}, 32'd4);
        check("exec_alusrca", {31'd0, bus.alusrca}, 32'd1);
        step(4'd7);
        check("rwb_reg", {29'd0, bus.regwrite, bus.regdst}, 32'b101);
        check("rwb_done", {31'd0, bus.instr_done}, 32'd1);
        step(4'd0);
        check("fetch_done", {31'd0, bus.instr_done}, 32'd0);
        // lw with two stalled MEMRD cycles; late opcode change must be ignored
        bus.opcode = 6'h23;
        step(4'd1);
        step(4'd2);
        check("memaddr_alusrcb", {30'd0, bus.alusrcb}, 32'd2);
        bus.opcode = 6'h3F;
        step(4'd3);
        bus.mem_ready = 1'b0;
        #1;
        check("memrd_rd_iord", {30'd0, bus.memread, bus.iord}, 32'b11);
        check("memrd_regwrite", {31'd0, bus.regwrite}, 32'd0);
        step(4'd3);
        check("memrd2_rd_iord", {30'd0, bus.memread, bus.iord}, 32'b11);
        step(4'd3);
        bus.mem_ready = 1'b1;
        step(4'd4);
        check("memwb_reg", {29'd0, bus.regwrite, bus.memtoreg}, 32'b101);
        check("memwb_done", {31'd0, bus.instr_done}, 32'd1);
        step(4'd0);
        // sw with one stalled MEMWR cycle
        bus.opcode = 6'h2B;
        check("fetch_memwrite", {31'd0, bus.memwrite}, 32'd0);
        step(4'd1);
        step(4'd2);
        step(4'd5);
        bus.mem_ready = 1'b0;
        #1;
        check("memwr_stall", {29'd0, bus.memwrite, bus.iord, bus.instr_done}, 32'b110);
        step(4'd5);
        bus.mem_ready = 1'b1;
        #1;
        check("memwr_done", {29'd0, bus.memwrite, bus.iord, bus.instr_done}, 32'b111);
        step(4'd0);
        // beq
        bus.opcode = 6'h04;
        step(4'd1);
        step(4'd8);
        check("beq_cond", {31'd0, bus.pcwritecond}, 32'd1);
        check("beq_aluop", {29'd0, bus.aluop}, 32'd1);
        check("beq_pcsrc", {30'd0, bus.pcsource}, 32'd1);
        check("beq_pcwrite", {31'd0, bus.pcwrite}, 32'd0);
        step(4'd0);
        // jal
        bus.opcode = 6'h03;
        step(4'd1);
        step(4'd10);
        check("jal_pc", {28'd0, bus.pcwrite, bus.regwrite, bus.pcsource}, 32'b1110);
        check("jal_reg", {28'd0, bus.regdst, bus.memtoreg}, 32'b1010);
        check("jal_done", {31'd0, bus.instr_done}, 32'd1);
        step(4'd0);
        // j
        bus.opcode = 6'h02;
        step(4'd1);
        step(4'd9);
        check("j_pc", {28'd0, bus.pcwrite, bus.regwrite, bus.pcsource}, 32'b1010);
        step(4'd0);
        // addi
        bus.opcode = 6'h08;
        step(4'd1);
        step(4'd11);
        check("addi_aluop", {29'd0, bus.aluop}, 32'd2);
        check("addi_alusrcb", {30'd0, bus.alusrcb}, 32'd2);
        step(4'd12);
        check("iwb_reg", {27'd0, bus.regwrite, bus.regdst, bus.memtoreg}, 32'b10000);
        check("iwb_done", {31'd0, bus.instr_done}, 32'd1);
        step(4'd0);
        // subi
        bus.opcode = 6'h09;
        step(4'd1);
        step(4'd11);
        check("subi_aluop", {29'd0, bus.aluop}, 32'd3);
        step(4'd12);
        step(4'd0);
        // illegal opcode halts until reset
        bus.opcode = 6'h3F;
        step(4'd1);
        for (int i = 0; i < 11; i++) begin
            step(4'd13);
            check("halt_flag", {31'd0, bus.halted}, 32'd1);
            check("halt_en", {27'd0, enables()}, 32'd0);
        end
        rst = 1'b1;
        step(4'd0);
        rst = 1'b0;
        check("halt_rst_halted", {31'd0, bus.halted}, 32'd0);
        // reset during stalled MEMRD
        bus.opcode = 6'h23;
        step(4'd1);
        step(4'd2);
        step(4'd3);
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        step(4'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("memrd_rst_regwrite", {31'd0, bus.regwrite}, 32'd0);
            step(4'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
